// File: rtl/btn_debounce_wb8_pkg.sv
// Shared types for the debounced button controller: bus byte and the
// register-select enumeration built on the address constants.
package btn_debounce_wb8_pkg;
  `include "btn_debounce_defs.vh"

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    SEL_STATE   = REG_STATE,
    SEL_PRESS   = REG_PRESS,
    SEL_RELEASE = REG_RELEASE,
    SEL_IRQMASK = REG_IRQMASK
  } reg_sel_t;
endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, stability counter and debounced
// state, with single-cycle rise/fall strobes aligned to the state toggle edge.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic raw,
  output logic state,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          state_reg;
  logic          differ;
  logic          expire;

  assign differ = sync_reg[1] ^ state_reg;
  // The counter would reach DEBOUNCE_CYCLES on this edge: toggle instead.
  assign expire = differ && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      state_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      if (!differ) begin
        cnt_reg <= '0;
      end else if (expire) begin
        cnt_reg   <= '0;
        state_reg <= ~state_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign state = state_reg;
  assign rise  = expire && !state_reg;
  assign fall  = expire && state_reg;
endmodule

// File: rtl/btn_debounce_defs.vh
// Register address map of the button controller, shared by the package and
// anything else that needs to decode the bus address.
localparam logic [1:0] REG_STATE   = 2'd0;
localparam logic [1:0] REG_PRESS   = 2'd1;
localparam logic [1:0] REG_RELEASE = 2'd2;
localparam logic [1:0] REG_IRQMASK = 2'd3;

// File: rtl/btn_debounce_wb8.sv
// Debounced button bank on an 8-bit bus: state, sticky press/release flags
// (write-1-to-clear) and an interrupt mask over the press flags.
module btn_debounce_wb8
  import btn_debounce_wb8_pkg::*;
#(
  parameter int CLOCKFREQ       = 25125000,
  parameter int DEBOUNCE_CYCLES = CLOCKFREQ / 100,
  parameter int NBUTTONS        = 5
) (
  input  logic                I_wb_clk,
  input  logic                I_reset,
  input  logic [1:0]          I_wb_adr,
  input  logic [7:0]          I_wb_dat,
  input  logic                I_wb_stb,
  input  logic                I_wb_we,
  output logic [7:0]          O_wb_dat,
  output logic                O_wb_ack,
  output logic                O_interrupt,
  input  logic [NBUTTONS-1:0] I_button
);
  localparam byte_t VALID = byte_t'((1 << NBUTTONS) - 1);

  logic [NBUTTONS-1:0] state_vec;
  logic [NBUTTONS-1:0] rise_vec;
  logic [NBUTTONS-1:0] fall_vec;

  byte_t state_b, rise_b, fall_b;
  byte_t press_reg, release_reg, mask_reg;
  byte_t press_next, release_next, mask_next;
  byte_t rdata, dat_reg;
  logic  ack_reg;
  logic  wr;

  genvar gi;
  generate
    for (gi = 0; gi < NBUTTONS; gi++) begin : g_ch
      btn_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk  (I_wb_clk),
        .srst (I_reset),
        .raw  (I_button[gi]),
        .state(state_vec[gi]),
        .rise (rise_vec[gi]),
        .fall (fall_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    state_b = '0;
    rise_b  = '0;
    fall_b  = '0;
    state_b[NBUTTONS-1:0] = state_vec;
    rise_b[NBUTTONS-1:0]  = rise_vec;
    fall_b[NBUTTONS-1:0]  = fall_vec;
  end

  assign wr = I_wb_stb && I_wb_we;

  // Clears are applied first so a new event on the same edge survives.
  always_comb begin
    press_next   = press_reg;
    release_next = release_reg;
    mask_next    = mask_reg;
    if (wr) begin
      case (reg_sel_t'(I_wb_adr))
        SEL_PRESS:   press_next   = press_reg & ~I_wb_dat;
        SEL_RELEASE: release_next = release_reg & ~I_wb_dat;
        SEL_IRQMASK: mask_next    = I_wb_dat & VALID;
        default:     ;
      endcase
    end
    press_next   = press_next | rise_b;
    release_next = release_next | fall_b;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel_t'(I_wb_adr))
      SEL_STATE:   rdata = state_b;
      SEL_PRESS:   rdata = press_reg;
      SEL_RELEASE: rdata = release_reg;
      SEL_IRQMASK: rdata = mask_reg;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      press_reg   <= '0;
      release_reg <= '0;
      mask_reg    <= '0;
      ack_reg     <= 1'b0;
      dat_reg     <= '0;
    end else begin
      press_reg   <= press_next;
      release_reg <= release_next;
      mask_reg    <= mask_next;
      ack_reg     <= I_wb_stb;
      dat_reg     <= I_wb_stb ? rdata : '0;
    end
  end

  assign O_wb_ack    = ack_reg;
  assign O_wb_dat    = dat_reg;
  assign O_interrupt = |(press_reg & mask_reg);
endmodule

// File: tb/tb_btn_debounce_wb8.sv
// Scoreboard bench: a window-based reference model predicts every read and
// the interrupt level; a negedge monitor compares whatever the DUT acks.
module tb_btn_debounce_wb8;
  localparam int DC   = 4;
  localparam int NB   = 5;
  localparam int HMAX = 16384;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [1:0]    adr  = '0;
  logic [7:0]    wdat = '0;
  logic          stb  = 1'b0;
  logic          we   = 1'b0;
  logic [NB-1:0] btn  = '0;
  logic [7:0]    rdat;
  logic          ack;
  logic          irq;

  btn_debounce_wb8 #(
    .CLOCKFREQ(25125000),
    .DEBOUNCE_CYCLES(DC),
    .NBUTTONS(NB)
  ) dut (
    .I_wb_clk   (clk),
    .I_reset    (rst),
    .I_wb_adr   (adr),
    .I_wb_dat   (wdat),
    .I_wb_stb   (stb),
    .I_wb_we    (we),
    .O_wb_dat   (rdat),
    .O_wb_ack   (ack),
    .O_interrupt(irq),
    .I_button   (btn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  bit armed = 0;

  function automatic void check(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h required 0x%02h (edge %0d)", name, got, exp, t);
    end
  endfunction

  // Reference model: raw levels per edge, and a button's state flips once the
  // last DC synchronized samples since its previous change all disagree with it.
  logic [NB-1:0] raw_hist [HMAX];
  int            rst_edge = 0;
  int            last_evt [NB];
  logic [NB-1:0] m_state = '0, m_press = '0, m_rel = '0, m_mask = '0;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
    string      what;
  } exp_t;
  exp_t sb[$];

  function automatic logic synced(int b, int u);
    if (u - 2 > rst_edge) return raw_hist[u-2][b];
    return 1'b0;
  endfunction

  function automatic logic settles(int b);
    for (int j = 0; j < DC; j++) begin
      if (t - j <= last_evt[b]) return 1'b0;
      if (synced(b, t - j) == m_state[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    logic [NB-1:0] rise, fall;
    exp_t e;
    t++;
    raw_hist[t] = btn;
    if (rst) begin
      rst_edge = t;
      m_state = '0; m_press = '0; m_rel = '0; m_mask = '0;
      for (int b = 0; b < NB; b++) last_evt[b] = t;
    end else begin
      if (stb) begin
        e.edge_n = t;
        case (adr)
          2'd0: begin e.data = {3'b0, m_state}; e.what = "rd_state";   end
          2'd1: begin e.data = {3'b0, m_press}; e.what = "rd_press";   end
          2'd2: begin e.data = {3'b0, m_rel};   e.what = "rd_release"; end
          default: begin e.data = {3'b0, m_mask}; e.what = "rd_mask"; end
        endcase
        sb.push_back(e);
      end
      rise = '0;
      fall = '0;
      for (int b = 0; b < NB; b++) begin
        if (settles(b)) begin
          if (m_state[b]) fall[b] = 1'b1;
          else rise[b] = 1'b1;
          last_evt[b] = t;
        end
      end
      if (stb && we) begin
        case (adr)
          2'd1: m_press = m_press & ~wdat[NB-1:0];
          2'd2: m_rel   = m_rel & ~wdat[NB-1:0];
          2'd3: m_mask  = wdat[NB-1:0];
          default: ;
        endcase
      end
      m_press = m_press | rise;
      m_rel   = m_rel | fall;
      m_state = m_state ^ (rise | fall);
    end
  end

  // Monitor: every ack must match the read issued on the preceding edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (armed) begin
      if (ack === 1'b1) begin
        if (sb.size() == 0 || sb[0].edge_n != t) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: ack=1 required 0 (edge %0d)", t);
        end else begin
          e = sb.pop_front();
          check(e.what, rdat, e.data);
        end
      end else if (sb.size() != 0 && sb[0].edge_n == t) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL ack_missing: ack=%b required 1 for %s (edge %0d)", ack, e.what, t);
      end
      check("irq_level", {7'b0, irq}, {7'b0, |(m_press & m_mask)});
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(bit w, logic [1:0] a, logic [7:0] d);
    stb = 1'b1; we = w; adr = a; wdat = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    int hold;
    for (int b = 0; b < NB; b++) last_evt[b] = 0;
    cyc(3);
    rst = 1'b0;
    armed = 1'b1;
    check("reset_ack", {7'b0, ack}, 8'h00);
    check("reset_dat", rdat, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);

    // Single read of the state register, ack lasts exactly one cycle.
    bus(0, 2'd0, 8'h00);
    check("ack_high", {7'b0, ack}, 8'h01);
    cyc(1);
    check("ack_single", {7'b0, ack}, 8'h00);

    // Short pulse on btn1 must be rejected.
    btn = 5'h02; cyc(3); btn = 5'h00; cyc(DC + 4);
    bus(0, 2'd0, 8'h00); bus(0, 2'd1, 8'h00); bus(0, 2'd2, 8'h00);

    // Clean press on btn0 with interrupt enabled, reading state every edge.
    bus(1, 2'd3, 8'h01);
    btn = 5'h01; stb = 1'b1; we = 1'b0; adr = 2'd0;
    cyc(5);
    check("irq_before_edge6", {7'b0, irq}, 8'h00);
    cyc(1);
    check("irq_at_edge6", {7'b0, irq}, 8'h01);
    adr = 2'd1; cyc(2); stb = 1'b0;

    // W1C of bit0 on the edge btn2 rises; then set-wins on bit4.
    btn = 5'h05; cyc(5); bus(1, 2'd1, 8'h01); bus(0, 2'd1, 8'h00);
    btn = 5'h15; cyc(5); bus(1, 2'd1, 8'h10); bus(0, 2'd1, 8'h00);

    // Release everything, then clear release and press flags.
    btn = 5'h00; cyc(DC + 4);
    bus(0, 2'd2, 8'h00); bus(0, 2'd0, 8'h00);
    bus(1, 2'd2, 8'hFF); bus(0, 2'd2, 8'h00);
    bus(1, 2'd1, 8'hFF); bus(0, 2'd1, 8'h00);

    // Reset while btn3's count is at 2; a strobe during reset gets no ack.
    btn = 5'h08; cyc(4);
    rst = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0;
    cyc(1);
    rst = 1'b0; stb = 1'b0;
    bus(0, 2'd3, 8'h00); bus(0, 2'd0, 8'h00); bus(0, 2'd1, 8'h00); bus(0, 2'd2, 8'h00);
    bus(1, 2'd3, 8'h08);
    check("irq_before_rel6", {7'b0, irq}, 8'h00);
    cyc(1);
    check("irq_at_rel6", {7'b0, irq}, 8'h01);
    bus(0, 2'd1, 8'h00);

    // Randomized phase: mixed pulse lengths, bus traffic, occasional reset.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn = btn ^ (NB'(1) << $urandom_range(0, NB - 1));
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      stb  = ($urandom_range(0, 2) == 0);
      we   = $urandom_range(0, 1);
      adr  = 2'($urandom_range(0, 3));
      wdat = 8'($urandom);
      rst  = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    stb = 1'b0; we = 1'b0; rst = 1'b0;
    cyc(DC + 4);
    check("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
